// File: rtl/ins_fetch.sv
// Instruction prefetcher: one outstanding memory read feeding a DEPTH-entry queue, flushed on redirect.
// Optional statistics counters are built only when INS_FETCH_STATS_EN is defined.
module ins_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        clear_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic [15:0] ins,
  output logic [15:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] stat_fetches,
  output logic [15:0] stat_discards
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_fetch_addr, w_fetch_addr_nxt;
  logic          r_mem_req, w_mem_req_nxt;
  logic [15:0]   r_mem_addr, w_mem_addr_nxt;
  logic [CW-1:0] r_count, w_count_after;
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [15:0]   r_q_ins [DEPTH];
  logic [15:0]   r_q_pc  [DEPTH];
  logic          w_push, w_pop, w_drop;

  // Redirect outranks both the consumer and the memory ack.
  assign w_pop = (r_count != '0) && ins_ready && !redirect;
  assign w_count_after = r_count + CW'(1) - CW'(w_pop);

  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_addr_nxt = r_fetch_addr;
    w_mem_addr_nxt   = r_mem_addr;
    w_push           = 1'b0;
    w_drop           = 1'b0;
    case (r_state)
      IDLE: begin
        if (redirect) begin
          w_state_nxt      = FETCH;
          w_fetch_addr_nxt = redirect_pc;
          w_mem_addr_nxt   = redirect_pc;
        end else if (r_count < DEPTH_C) begin
          w_state_nxt    = FETCH;
          w_mem_addr_nxt = r_fetch_addr;
        end
      end
      FETCH: begin
        if (redirect) begin
          w_fetch_addr_nxt = redirect_pc;
          if (mem_ack) begin
            w_drop         = 1'b1;
            w_mem_addr_nxt = redirect_pc;
          end else begin
            w_state_nxt = DISCARD;
          end
        end else if (mem_ack) begin
          w_push           = 1'b1;
          w_fetch_addr_nxt = r_fetch_addr + 16'd1;
          if (w_count_after < DEPTH_C) begin
            w_mem_addr_nxt = r_fetch_addr + 16'd1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect) w_fetch_addr_nxt = redirect_pc;
        if (mem_ack) begin
          w_drop         = 1'b1;
          w_state_nxt    = FETCH;
          w_mem_addr_nxt = redirect ? redirect_pc : r_fetch_addr;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_mem_req_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state      <= IDLE;
      r_fetch_addr <= RESET_PC;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
    end
  end

  // In FETCH the request address is the pc of the word being returned.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_ins[i] <= '0;
        r_q_pc[i]  <= '0;
      end
    end else if (redirect) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        r_q_ins[r_wr_ptr] <= mem_data;
        r_q_pc[r_wr_ptr]  <= r_mem_addr;
        r_wr_ptr          <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign ins       = r_q_ins[r_rd_ptr];
  assign ins_pc    = r_q_pc[r_rd_ptr];
  assign ins_valid = (r_count != '0);

`ifdef INS_FETCH_STATS_EN
  logic [15:0] r_stat_fetches, r_stat_discards;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_stat_fetches  <= '0;
      r_stat_discards <= '0;
    end else begin
      if (w_push && (r_stat_fetches != 16'hFFFF)) r_stat_fetches <= r_stat_fetches + 16'd1;
      if (w_drop && (r_stat_discards != 16'hFFFF)) r_stat_discards <= r_stat_discards + 16'd1;
    end
  end

  assign stat_fetches  = r_stat_fetches;
  assign stat_discards = r_stat_discards;
`else
  assign stat_fetches  = 16'h0000;
  assign stat_discards = 16'h0000;
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: streaming, full queue, redirects (pending, coincident, wrap) and async reset.
module tb_ins_fetch;

`ifdef INS_FETCH_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        clear_n, mem_ack, ins_ready, redirect;
  logic [15:0] mem_data, redirect_pc;
  logic        mem_req, ins_valid;
  logic [15:0] mem_addr, ins, ins_pc, stat_fetches, stat_discards;
  logic        auto_ack, man_ack;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return a ^ 16'hBEEF;
  endfunction

  assign mem_ack  = auto_ack ? mem_req : man_ack;
  assign mem_data = rom(mem_addr);

  ins_fetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .clear_n(clear_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stat_fetches(stat_fetches), .stat_discards(stat_discards)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          acks;
    bit          found;
    logic [15:0] wrap_pc [3];
    wrap_pc[0] = 16'hFFFE; wrap_pc[1] = 16'hFFFF; wrap_pc[2] = 16'h0000;

    clear_n = 1'b0; ins_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    auto_ack = 1'b0; man_ack = 1'b0;
    step(); step();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_ins_valid", ins_valid, 0);
    check("rst_ins", ins, 0);
    check("rst_ins_pc", ins_pc, 0);
    check("rst_stats", {stat_fetches, stat_discards}, 0);

    // Streaming: one instruction per cycle from RESET_PC
    clear_n = 1'b1; auto_ack = 1'b1; ins_ready = 1'b1;
    step();
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      step();
      check("stream_valid", ins_valid, 1);
      check("stream_pc", ins_pc, i);
      check("stream_ins", ins, rom(16'(i)));
    end

    // Consumer stalled: queue fills with exactly DEPTH words
    clear_n = 1'b0; ins_ready = 1'b0;
    step();
    clear_n = 1'b1; acks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_req && mem_ack) acks++;
    end
    check("full_acks", acks, 4);
    check("full_req", mem_req, 0);
    check("full_valid", ins_valid, 1);
    check("full_pc", ins_pc, 0);
    check("full_stat_fetch", stat_fetches, 4 * STATS);

    // Redirect while a request to address 5 waits for a slow ack
    clear_n = 1'b0; ins_ready = 1'b1; auto_ack = 1'b1;
    step();
    clear_n = 1'b1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mem_req && mem_addr == 16'd5) found = 1'b1;
    end
    auto_ack = 1'b0; man_ack = 1'b0;
    check("pend5_reached", found, 1);
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    check("disc_valid", ins_valid, 0);
    check("disc_req", mem_req, 1);
    check("disc_addr_hold", mem_addr, 5);
    step();
    check("disc_addr_hold2", mem_addr, 5);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    check("disc_valid2", ins_valid, 0);
    check("redir_req", mem_req, 1);
    check("redir_addr", mem_addr, 16'h0040);
    auto_ack = 1'b1;
    step();
    check("redir_valid", ins_valid, 1);
    check("redir_pc", ins_pc, 16'h0040);
    check("redir_ins", ins, rom(16'h0040));
    check("stat_disc1", stat_discards, STATS);

    // Redirect coinciding with ack and ready
    redirect = 1'b1; redirect_pc = 16'h1234;
    step();
    redirect = 1'b0;
    check("coin_valid", ins_valid, 0);
    check("coin_addr", mem_addr, 16'h1234);
    check("coin_req", mem_req, 1);
    check("stat_disc2", stat_discards, 2 * STATS);
    step();
    check("coin_pc", ins_pc, 16'h1234);

    // Address wrap
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    check("wrap_gap", ins_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("wrap_pc", ins_pc, wrap_pc[i]);
      check("wrap_ins", ins, rom(wrap_pc[i]));
    end

    // Asynchronous reset with a request outstanding
    auto_ack = 1'b0; man_ack = 1'b0;
    step();
    check("out_req", mem_req, 1);
    #2 clear_n = 1'b0;
    #1;
    check("arst_req", mem_req, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_valid", ins_valid, 0);
    check("arst_pc", ins_pc, 0);
    check("arst_ins", ins, 0);
    step();
    man_ack = 1'b1; clear_n = 1'b1;
    step();
    check("rel_req", mem_req, 1);
    check("rel_addr", mem_addr, 16'h0000);
    check("rel_stray_ack", ins_valid, 0);
    man_ack = 1'b0;
    step();
    check("rel_no_push", ins_valid, 0);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    check("rel_valid", ins_valid, 1);
    check("rel_pc", ins_pc, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
